vm1_pwr_seq: RTL and testbench
==============================

// Module: vm1_pwr_seq
// PURPOSE
//   Parametrised power/reset sequencer for VM1 systems; replaces the fixed 8-bit button reset stretcher.
//   Debounces a raw reset button and a power-fail request, and drives DCLO/ACLO in Q-bus order:
//   - power-up: DCLO falls, then ACLO falls.
//   - power-fail: ACLO rises, CPU gets a save window, then DCLO rises.
//   Sits in the board top; the top inverts dclo/aclo onto pin_dclo_n/pin_aclo_n.
// PARAMETERS
//   DEB_CNT  4096  consecutive enabled samples needed to accept a new debounced level (>=1)
//   T_DCLO   1024  enabled cycles DCLO is held after a stable release (>=1)
//   T_ACLO   4096  enabled cycles from DCLO deassert to ACLO deassert (>=1)
//   T_FAIL   2048  enabled cycles from ACLO assert to DCLO assert on power-fail (>=1)
// PORTS
//   clk       in   1  system clock
//   reset     in   1  asynchronous reset, active-high
//   ena       in   1  timebase enable; counters and FSM advance only when 1
//   btn_n     in   1  raw asynchronous reset button, 0 = pressed
//   pwr_fail  in   1  raw asynchronous power-fail request, 1 = fail
//   dclo      out  1  DC-low to CPU, 1 = asserted
//   aclo      out  1  AC-low to CPU, 1 = asserted
//   busy      out  1  1 whenever state != RUN
//   state     out  3  FSM state: RESET=0, DHOLD=1, AWAIT=2, RUN=3, FAIL=4, DOWN=5
// BEHAVIOUR
//   Reset values
//   - dclo=1, aclo=1, busy=1, state=RESET, sync flops=0, counters=0.
//   - Debounced button = pressed; debounced fail = 0.
//   Synchronisers and debouncers
//   - btn_n and pwr_fail each pass a 2-flop synchroniser clocked every clk, independent of ena.
//   - Each input has its own debouncer with a counter sized $clog2(DEB_CNT+1).
//     - On an enabled edge where the sync output differs from the debounced level, the counter increments.
//     - When it equals DEB_CNT-1 and still differs, the debounced level takes the new value and the counter clears.
//     - On an enabled edge where sync equals the debounced level, the counter clears.
//   - Latency: a raw change becomes a debounced change at edge 2+DEB_CNT (ena=1).
//   FSM
//   - One shared phase counter, sized for max(T_DCLO,T_ACLO,T_FAIL); it clears on every state entry.
//   - A state with period T ends on the enabled edge where counter==T-1, so it lasts exactly T enabled cycles.
//   - dclo and aclo are registered and change on the same edge as the state transition.
//   Transitions
//   - RESET: dclo=1, aclo=1. Debounced button released and debounced fail=0 -> DHOLD on the next enabled edge.
//   - DHOLD: dclo=1, aclo=1. After T_DCLO -> AWAIT with dclo<=0.
//   - AWAIT: dclo=0, aclo=1. After T_ACLO -> RUN with aclo<=0.
//   - RUN: dclo=0, aclo=0. Debounced press or debounced fail -> FAIL with aclo<=1.
//   - FAIL: dclo=0, aclo=1. After T_FAIL -> DOWN with dclo<=1.
//     A further press or fail during FAIL is ignored; the save window is always completed.
//   - DOWN: dclo=1, aclo=1. Button released and fail=0 -> DHOLD.
//   Aborts and precedence
//   - A press or fail during DHOLD or AWAIT aborts to DOWN, with dclo<=1 and aclo<=1 on the same edge.
//   - When press and fail occur on the same edge they act identically; there is no priority.
//   Other rules
//   - ena=0 freezes the FSM, phase counter and debounce counters; synchronisers still run.
//   - Asserting reset mid-sequence forces the reset values immediately, with no save window.
//   - dclo=0 with aclo=0 is only ever presented in RUN. dclo=0 with aclo=1 is only presented in AWAIT and FAIL.
// TESTING  (DEB_CNT=4, T_DCLO=8, T_ACLO=16, T_FAIL=6, ena=1, edge 0 = first edge after reset falls)
//   1 Power-up: btn_n=1 and pwr_fail=0 from reset.
//     -> state=DHOLD at edge 7; dclo 1->0 at edge 15; aclo 1->0 and state=RUN at edge 31.
//   2 Press: btn_n driven 0 just after edge 100 while in RUN.
//     -> state=FAIL and aclo=1 at edge 107; dclo=1 and state=DOWN at edge 113.
//     Release at 200 -> DHOLD at edge 207.
//   3 Bounce: btn_n pulses 0 for 3 cycles, then returns to 1.
//     -> no debounced change; dclo=0, aclo=0 and state=RUN throughout.
//   4 Abort: press so the debounced change lands during AWAIT.
//     -> DOWN on the next edge with dclo=1 and aclo=1; the FAIL state is never entered.
//   5 ena gating: ena=1 every 3rd clk during power-up.
//     -> every event of test 1 occurs at 3x the enabled-edge count; no output glitch.
//   6 Async reset in FAIL: assert reset at edge 110.
//     -> dclo=1, aclo=1, state=0 before the next edge; the sequence then restarts as in test 1.

Source files
------------

// File: rtl/vm1_pwr_seq.sv
// ---------------------------------------------------------------------------
// vm1_pwr_seq
//
// Power/reset sequencer for VM1 systems. A raw reset button and a raw
// power-fail request are each synchronised and debounced, then a small FSM
// drives DCLO/ACLO in Q-bus order:
//   power-up  : DCLO falls first, ACLO falls T_ACLO enabled cycles later.
//   power-fail: ACLO rises, the CPU gets T_FAIL enabled cycles to save
//               state, then DCLO rises.
// The board top inverts dclo/aclo onto the active-low bus pins.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous reset, active-high
//   ena       in   timebase enable; debouncers and FSM advance only when 1
//   btn_n     in   raw asynchronous reset button, 0 = pressed
//   pwr_fail  in   raw asynchronous power-fail request, 1 = fail
//   dclo      out  DC-low to CPU, 1 = asserted (registered)
//   aclo      out  AC-low to CPU, 1 = asserted (registered)
//   busy      out  1 whenever the FSM is not in RUN (registered)
//   state     out  FSM state: RESET=0 DHOLD=1 AWAIT=2 RUN=3 FAIL=4 DOWN=5
// ---------------------------------------------------------------------------
module vm1_pwr_seq #(
    parameter int DEB_CNT = 4096,
    parameter int T_DCLO  = 1024,
    parameter int T_ACLO  = 4096,
    parameter int T_FAIL  = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       btn_n,
    input  logic       pwr_fail,
    output logic       dclo,
    output logic       aclo,
    output logic       busy,
    output logic [2:0] state
);

    // Debounce counter width and terminal value.
    localparam int               DW       = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CNT - 1);
    localparam logic [DW-1:0]    DEB_ONE  = DW'(1);

    // Phase counter is shared by all timed states, so it is sized for the
    // longest period.
    localparam int T_MAX01 = (T_DCLO > T_ACLO) ? T_DCLO : T_ACLO;
    localparam int T_MAX   = (T_MAX01 > T_FAIL) ? T_MAX01 : T_FAIL;
    localparam int PW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [PW-1:0] PH_DCLO = PW'(T_DCLO - 1);
    localparam logic [PW-1:0] PH_ACLO = PW'(T_ACLO - 1);
    localparam logic [PW-1:0] PH_FAIL = PW'(T_FAIL - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_DHOLD = 3'd1,
        S_AWAIT = 3'd2,
        S_RUN   = 3'd3,
        S_FAIL  = 3'd4,
        S_DOWN  = 3'd5
    } state_t;

    // Bit 0 carries the button level (btn_n polarity), bit 1 the fail request.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q,  deb_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q,    ph_d;
    logic          dclo_q,  dclo_d;
    logic          aclo_q,  aclo_d;
    logic          busy_q,  busy_d;

    logic          trip;
    logic          clear;

    assign raw = {pwr_fail, btn_n};

    // Two-flop synchronisers run on every clock, independent of ena.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // A new level is accepted only after DEB_CNT consecutive enabled samples
    // that disagree with the current debounced level; any agreeing sample
    // restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = dcnt_q[i];
            if (ena) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (dcnt_q[i] == DEB_LAST) begin
                        deb_d[i]  = sync2_q[i];
                        dcnt_d[i] = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DEB_ONE;
                    end
                end else begin
                    dcnt_d[i] = '0;
                end
            end
        end
    end

    // Debounced button starts as pressed (level 0), fail as inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    // Press and fail are treated identically: either one trips the sequence.
    assign trip  = ~deb_q[0] | deb_q[1];
    assign clear = ~trip;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        dclo_d  = dclo_q;
        aclo_d  = aclo_q;
        if (ena) begin
            unique case (state_q)
                S_RESET: begin
                    dclo_d = 1'b1;
                    aclo_d = 1'b1;
                    if (clear) state_d = S_DHOLD;
                end
                S_DHOLD: begin
                    // An abort during power-up wins over a timeout on the
                    // same edge, so a half-started CPU is never released.
                    if (trip) begin
                        state_d = S_DOWN;
                        dclo_d  = 1'b1;
                        aclo_d  = 1'b1;
                    end else if (ph_q == PH_DCLO) begin
                        state_d = S_AWAIT;
                        dclo_d  = 1'b0;
                    end else begin
                        ph_d = ph_q + PH_ONE;
                    end
                end
                S_AWAIT: begin
                    if (trip) begin
                        state_d = S_DOWN;
                        dclo_d  = 1'b1;
                        aclo_d  = 1'b1;
                    end else if (ph_q == PH_ACLO) begin
                        state_d = S_RUN;
                        aclo_d  = 1'b0;
                    end else begin
                        ph_d = ph_q + PH_ONE;
                    end
                end
                S_RUN: begin
                    if (trip) begin
                        state_d = S_FAIL;
                        aclo_d  = 1'b1;
                    end
                end
                S_FAIL: begin
                    // The save window always runs to completion; further
                    // presses or fails are not looked at here.
                    if (ph_q == PH_FAIL) begin
                        state_d = S_DOWN;
                        dclo_d  = 1'b1;
                    end else begin
                        ph_d = ph_q + PH_ONE;
                    end
                end
                S_DOWN: begin
                    dclo_d = 1'b1;
                    aclo_d = 1'b1;
                    if (clear) state_d = S_DHOLD;
                end
                default: begin
                    state_d = S_RESET;
                    dclo_d  = 1'b1;
                    aclo_d  = 1'b1;
                end
            endcase
            // Every state entry starts its period from zero.
            if (state_d != state_q) ph_d = '0;
        end
        busy_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            ph_q    <= '0;
            dclo_q  <= 1'b1;
            aclo_q  <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            dclo_q  <= dclo_d;
            aclo_q  <= aclo_d;
            busy_q  <= busy_d;
        end
    end

    assign dclo  = dclo_q;
    assign aclo  = aclo_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule

// File: tb/tb_vm1_pwr_seq.sv
module tb_vm1_pwr_seq;

    localparam int DEB = 4;
    localparam int TD  = 8;
    localparam int TA  = 16;
    localparam int TF  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       btn_n;
    logic       pwr_fail;
    logic       dclo;
    logic       aclo;
    logic       busy;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vm1_pwr_seq #(
        .DEB_CNT (DEB),
        .T_DCLO  (TD),
        .T_ACLO  (TA),
        .T_FAIL  (TF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .btn_n    (btn_n),
        .pwr_fail (pwr_fail),
        .dclo     (dclo),
        .aclo     (aclo),
        .busy     (busy),
        .state    (state)
    );

    // One record per checkpoint: outputs expected just after edge en, then
    // the raw inputs to drive from that point on.
    typedef struct {
        int         en;
        logic       btn_n;
        logic       pf;
        logic [2:0] st;
        logic       dclo;
        logic       aclo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int en, input logic b, input logic pf,
                                input logic [2:0] st, input logic d, input logic a);
        vec_t v;
        v.en = en; v.btn_n = b; v.pf = pf; v.st = st; v.dclo = d; v.aclo = a;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic d, input logic a);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_dclo"},  32'(dclo),  32'(d));
        chk({tag, "_aclo"},  32'(aclo),  32'(a));
        chk({tag, "_busy"},  32'(busy),  32'(st != 3'd3));
    endtask

    // Holds reset with the button pressed, checks reset values, and releases
    // reset between edges so the following posedge is edge 0.
    task automatic do_reset(input string tag);
        reset    = 1'b1;
        btn_n    = 1'b0;
        pwr_fail = 1'b0;
        ena      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outs(tag, 3'd0, 1'b1, 1'b1);
        reset = 1'b0;
    endtask

    // n-th edge strictly after 'after' on which ena is high when ena is
    // pulsed on every div-th edge.
    function automatic int nth_en(input int after, input int n, input int div);
        int e = after;
        int k = 0;
        while (k < n) begin
            e++;
            if (e % div == 0) k++;
        end
        return e;
    endfunction

    // Button released just after edge 0; the synchronised level is visible
    // from edge 3 onward, so debounce counting uses enabled edges after 2.
    task automatic powerup(input int div, input string tag);
        int db, dh, aw, rn;
        logic [2:0] st;
        db = nth_en(2, DEB, div);
        dh = nth_en(db, 1, div);
        aw = nth_en(dh, TD, div);
        rn = nth_en(aw, TA, div);
        for (int e = 0; e <= rn + 2; e++) begin
            @(posedge clk);
            #1;
            st = (e < dh) ? 3'd0 : (e < aw) ? 3'd1 : (e < rn) ? 3'd2 : 3'd3;
            check_outs($sformatf("%s_e%0d", tag, e), st, e < aw, e < rn);
            if (e == 0) btn_n = 1'b1;
            ena = ((e + 1) % div == 0);
        end
        ena = 1'b1;
    endtask

    initial begin
        int idx;

        // power-up, bounce, press with overlapping fail, release, abort in
        // AWAIT, fail-triggered shutdown, and a final press into FAIL
        tbl.push_back(mk(  0, 1, 0, 3'd0, 1, 1));
        tbl.push_back(mk(  6, 1, 0, 3'd0, 1, 1));
        tbl.push_back(mk(  7, 1, 0, 3'd1, 1, 1));
        tbl.push_back(mk( 14, 1, 0, 3'd1, 1, 1));
        tbl.push_back(mk( 15, 1, 0, 3'd2, 0, 1));
        tbl.push_back(mk( 30, 1, 0, 3'd2, 0, 1));
        tbl.push_back(mk( 31, 1, 0, 3'd3, 0, 0));
        tbl.push_back(mk( 50, 0, 0, 3'd3, 0, 0));
        tbl.push_back(mk( 53, 1, 0, 3'd3, 0, 0));
        tbl.push_back(mk( 55, 1, 0, 3'd3, 0, 0));
        tbl.push_back(mk( 60, 1, 0, 3'd3, 0, 0));
        tbl.push_back(mk(100, 0, 0, 3'd3, 0, 0));
        tbl.push_back(mk(101, 0, 1, 3'd3, 0, 0));
        tbl.push_back(mk(106, 0, 1, 3'd3, 0, 0));
        tbl.push_back(mk(107, 0, 1, 3'd4, 0, 1));
        tbl.push_back(mk(112, 0, 1, 3'd4, 0, 1));
        tbl.push_back(mk(113, 0, 1, 3'd5, 1, 1));
        tbl.push_back(mk(150, 0, 0, 3'd5, 1, 1));
        tbl.push_back(mk(200, 1, 0, 3'd5, 1, 1));
        tbl.push_back(mk(206, 1, 0, 3'd5, 1, 1));
        tbl.push_back(mk(207, 1, 0, 3'd1, 1, 1));
        tbl.push_back(mk(215, 0, 0, 3'd2, 0, 1));
        tbl.push_back(mk(221, 0, 0, 3'd2, 0, 1));
        tbl.push_back(mk(222, 0, 0, 3'd5, 1, 1));
        tbl.push_back(mk(240, 1, 0, 3'd5, 1, 1));
        tbl.push_back(mk(246, 1, 0, 3'd5, 1, 1));
        tbl.push_back(mk(247, 1, 0, 3'd1, 1, 1));
        tbl.push_back(mk(255, 1, 0, 3'd2, 0, 1));
        tbl.push_back(mk(271, 1, 0, 3'd3, 0, 0));
        tbl.push_back(mk(280, 1, 1, 3'd3, 0, 0));
        tbl.push_back(mk(286, 1, 1, 3'd3, 0, 0));
        tbl.push_back(mk(287, 1, 1, 3'd4, 0, 1));
        tbl.push_back(mk(293, 1, 1, 3'd5, 1, 1));
        tbl.push_back(mk(300, 1, 0, 3'd5, 1, 1));
        tbl.push_back(mk(306, 1, 0, 3'd5, 1, 1));
        tbl.push_back(mk(307, 1, 0, 3'd1, 1, 1));
        tbl.push_back(mk(315, 1, 0, 3'd2, 0, 1));
        tbl.push_back(mk(331, 1, 0, 3'd3, 0, 0));
        tbl.push_back(mk(340, 0, 0, 3'd3, 0, 0));
        tbl.push_back(mk(346, 0, 0, 3'd3, 0, 0));
        tbl.push_back(mk(347, 0, 0, 3'd4, 0, 1));

        do_reset("reset");

        idx = 0;
        for (int e = 0; e <= 347; e++) begin
            @(posedge clk);
            #1;
            // the abort from AWAIT must go straight to DOWN, never via FAIL
            if (e >= 216 && e <= 246)
                chk($sformatf("abort_nofail_e%0d", e), 32'(state == 3'd4), 32'd0);
            while (idx < tbl.size() && tbl[idx].en == e) begin
                check_outs($sformatf("vec_e%0d", e), tbl[idx].st, tbl[idx].dclo, tbl[idx].aclo);
                btn_n    = tbl[idx].btn_n;
                pwr_fail = tbl[idx].pf;
                idx++;
            end
        end

        // asynchronous reset while in FAIL: outputs return before any edge
        #3;
        reset = 1'b1;
        #1;
        check_outs("async_rst", 3'd0, 1'b1, 1'b1);
        do_reset("async_hold");
        powerup(1, "restart");

        // enable pulsed on every third clock during power-up
        do_reset("gated_rst");
        powerup(3, "gated");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
